alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Upstream issue stage for the team's 16-bit combinational ALU (a, b, 4-bit sel -> out, carry).
//  Holds a small operand register file and accepts one instruction at a time over a valid/ready handshake.
//  Drives registered a/b/sel to the ALU, then writes the ALU result and carry back to the register file.
//  Supports a load-immediate path that bypasses the ALU.
// PARAMETERS
//  WIDTH   16  datapath width; must match the ALU
//  NREGS    4  register file depth; address width is clog2(NREGS)=2
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  instr_valid  in   1      instruction present
//  instr_ready  out  1      stage idle and able to accept
//  instr_ld     in   1      1 = load immediate into rd; 0 = ALU op
//  instr_op     in   4      ALU sel code, 0x0..0xF; all 16 are legal
//  instr_rd     in   2      destination register
//  instr_rs1    in   2      source for ALU a
//  instr_rs2    in   2      source for ALU b
//  instr_imm    in   WIDTH  immediate; used only when instr_ld=1
//  alu_a        out  WIDTH  to ALU a, registered
//  alu_b        out  WIDTH  to ALU b, registered
//  alu_sel      out  4      to ALU sel, registered
//  alu_out      in   WIDTH  from ALU
//  alu_carry    in   1      from ALU
//  done         out  1      1-cycle pulse on writeback
//  carry_flag   out  1      carry of the last ALU op
//  rd_addr      in   2      debug/readback address
//  rd_data      out  WIDTH  combinational read of regfile[rd_addr]
// BEHAVIOUR
//  - Reset: all regs 0; alu_a/alu_b/alu_sel 0; done 0; carry_flag 0; state IDLE.
//  - instr_ready is forced 0 while rst=1.
//  - FSM states: IDLE, ISSUE, WB. instr_ready = (state==IDLE) && !rst.
//  - IDLE: on instr_valid&&instr_ready, latch all instr_* fields.
//    Go to WB if instr_ld=1, else go to ISSUE.
//  - ISSUE: alu_a <= reg[rs1], alu_b <= reg[rs2], alu_sel <= op. Go to WB.
//  - WB, ALU op: reg[rd] <= alu_out; carry_flag <= alu_carry; done=1; go to IDLE.
//  - WB, load: reg[rd] <= imm; carry_flag unchanged; done=1; go to IDLE.
//  - Latency, ALU op: accept in cycle 0; ALU inputs valid from cycle 1; done in cycle 2.
//    Result is visible on rd_data in cycle 3; next accept is in cycle 3.
//  - Latency, load: accept in cycle 0; done in cycle 1; next accept in cycle 2.
//  - alu_a/alu_b/alu_sel hold their last values outside ISSUE; they are never cleared except by reset.
//  - rd equal to rs1 or rs2: sources are the pre-write values latched in ISSUE.
//  - instr_valid while busy: not accepted, no side effects. Fields may change while ready=0.
//  - Reset mid-operation: instruction aborted, no writeback, no done pulse.
//  - Arithmetic is owned by the ALU. This block does no width extension; writeback is WIDTH bits exactly.
// CONFIGURATION
//  ALU_ISSUE_ZERO_FLAG_EN:
//  - Defined: adds output port zero_flag (1 bit), reset 0, updated in WB to (written value == 0).
//    Updated for both ALU ops and loads.
//  - Undefined: port absent, no logic.
// STRUCTURE
//  - Package alu_issue_pkg: state enum {IDLE, ISSUE, WB}; WIDTH_DEF=16; OP_W=4; RADDR_W=2.
//  - Sub-module alu_issue_regfile: NREGS x WIDTH, 1 synchronous write port, 3 async read ports (rs1, rs2, rd_addr).
// TESTING
//  Bench ALU model: sel 0 = a+b with carry-out; sel 1 = a&b.
//  1. Reset, then check: ready=1, carry_flag=0, rd_data=0 for all 4 addresses.
//  2. ld r0=0x002A, ld r1=0x00A2, op0 r2=r0+r1.
//     -> alu_a=0x002A, alu_b=0x00A2 in ISSUE; r2=0x00CC; carry_flag=0; done at cycle 2.
//  3. ld r0=0xFFFF, ld r1=0x0001, op0 r0=r0+r1.
//     -> r0=0x0000, carry_flag=1 (zero_flag=1 when enabled).
//  4. Hold instr_valid for 3 cycles with different fields during ISSUE/WB.
//     -> only the first instruction executes; exactly one done pulse.
//  5. Assert rst in the ISSUE cycle of op1 r3=r0&r1.
//     -> r3 stays 0, no done pulse, ready=1 the cycle after rst drops.
//  6. ld r1=0x00F0, then op1 r1=r1&r1.
//     -> r1=0x00F0; back-to-back accepts at the ready-edge spacing above.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue stage.
// Optional feature macro used by the top: ALU_ISSUE_ZERO_FLAG_EN.
package alu_issue_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int OP_W      = 4;
  localparam int RADDR_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_e;

endpackage

// File: rtl/alu_issue_regfile.sv
// Operand register file: NREGS x WIDTH, one synchronous write port and
// three asynchronous read ports; synchronous reset clears every entry.
module alu_issue_regfile
  import alu_issue_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [RADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [RADDR_W-1:0] raddr0,
  output logic [WIDTH-1:0]   rdata0,
  input  logic [RADDR_W-1:0] raddr1,
  output logic [WIDTH-1:0]   rdata1,
  input  logic [RADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]   rdata2
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign rdata0 = regs_q[raddr0];
  assign rdata1 = regs_q[raddr1];
  assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the 16-bit combinational ALU: accepts one instruction at a
// time, drives registered operands, writes back result/carry or an immediate.
// Optional zero_flag output is enabled by defining ALU_ISSUE_ZERO_FLAG_EN.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = 4
) (
  input  logic               clk,
  input  logic               rst,
  // Handshake: an instruction transfers on a rising edge where
  // instr_valid && instr_ready; fields are ignored whenever instr_ready is 0.
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               instr_ld,
  input  logic [OP_W-1:0]    instr_op,
  input  logic [RADDR_W-1:0] instr_rd,
  input  logic [RADDR_W-1:0] instr_rs1,
  input  logic [RADDR_W-1:0] instr_rs2,
  input  logic [WIDTH-1:0]   instr_imm,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [OP_W-1:0]    alu_sel,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_carry,
  output logic               done,
  output logic               carry_flag,
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  output logic               zero_flag,
`endif
  input  logic [RADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]   rd_data,
  output state_e             dbg_state
);

  state_e             state_q, state_d;
  logic               ld_q, ld_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic [WIDTH-1:0]   imm_q, imm_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [OP_W-1:0]    alu_sel_q, alu_sel_d;
  logic               carry_q, carry_d;

  logic               accept;
  logic               wb_we;
  logic [WIDTH-1:0]   wb_data;
  logic [WIDTH-1:0]   rs1_data;
  logic [WIDTH-1:0]   rs2_data;

  alu_issue_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_we),
    .waddr  (rd_q),
    .wdata  (wb_data),
    .raddr0 (instr_rs1),
    .rdata0 (rs1_data),
    .raddr1 (instr_rs2),
    .rdata1 (rs2_data),
    .raddr2 (rd_addr),
    .rdata2 (rd_data)
  );

  assign instr_ready = (state_q == IDLE) && !rst;
  assign accept      = instr_valid && instr_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = instr_ld ? WB : ISSUE;
      ISSUE:   state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / writeback logic
  always_comb begin
    done    = (state_q == WB);
    wb_we   = done;
    wb_data = ld_q ? imm_q : alu_out;
    carry_d = (done && !ld_q) ? alu_carry : carry_q;
  end

  // Operands are captured from the regfile at accept, so the ALU sees them for
  // the whole ISSUE cycle and a write to rd can never feed back into them.
  always_comb begin
    ld_d      = ld_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    if (accept) begin
      ld_d  = instr_ld;
      rd_d  = instr_rd;
      imm_d = instr_imm;
      if (!instr_ld) begin
        alu_a_d   = rs1_data;
        alu_b_d   = rs2_data;
        alu_sel_d = instr_op;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_q      <= 1'b0;
      rd_q      <= '0;
      imm_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      carry_q   <= 1'b0;
    end else begin
      ld_q      <= ld_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      carry_q   <= carry_d;
    end
  end

`ifdef ALU_ISSUE_ZERO_FLAG_EN
  logic zero_q, zero_d;

  always_comb begin
    zero_d = done ? (wb_data == '0) : zero_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign zero_flag = zero_q;
`endif

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign carry_flag = carry_q;
  assign dbg_state  = state_q;

endmodule
